// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, control
// constants, sequencer state encodings and op classification helpers.
package mdu_ctrl_pkg;

  localparam logic Valid     = 1'b1;
  localparam logic Invalid   = 1'b0;
  localparam logic RstEnable = 1'b0;

  localparam logic [5:0] Mult  = 6'b011000;
  localparam logic [5:0] Multu = 6'b011001;
  localparam logic [5:0] Div   = 6'b011010;
  localparam logic [5:0] Divu  = 6'b011011;

  typedef enum logic [1:0] {
    MduIdle = 2'd0,
    MduCalc = 2'd1,
    MduFix  = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [5:0] op);
    return (op == Mult) || (op == Multu) || (op == Div) || (op == Divu);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == Mult) || (op == Div);
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == Div) || (op == Divu);
  endfunction

endpackage

// File: rtl/mdu_ctrl_iter.sv
// Per-cycle datapath of the multiply/divide unit: one shift-add multiply
// step or one restoring-divide step, plus the final sign fixup.
// Purely combinational; the sequencer owns all state.
module mdu_iter
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic             prod_neg_i,
  input  logic             rem_neg_i,
  input  logic             div_zero_i,
  output logic [WIDTH-1:0] nxt_hi_o,
  output logic [WIDTH-1:0] nxt_lo_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [WIDTH:0]            sum;
  logic [WIDTH:0]            shifted;
  logic [WIDTH:0]            diff;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;

  // One iteration: multiply adds into the upper half and shifts right keeping
  // the carry; divide shifts {rem,quot} left and conditionally subtracts.
  always_comb begin
    sum      = {1'b0, acc_hi_i};
    shifted  = {acc_hi_i, acc_lo_i[WIDTH-1]};
    diff     = shifted - {1'b0, opnd_i};
    nxt_hi_o = acc_hi_i;
    nxt_lo_o = acc_lo_i;
    if (is_div_i) begin
      // The shifted remainder can need WIDTH+1 bits for large unsigned divisors.
      if (shifted >= {1'b0, opnd_i}) begin
        nxt_hi_o = diff[WIDTH-1:0];
        nxt_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi_o = shifted[WIDTH-1:0];
        nxt_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_lo_i[0]) begin
        sum = {1'b0, acc_hi_i} + {1'b0, opnd_i};
      end
      nxt_hi_o = sum[WIDTH:1];
      nxt_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes; a zero divisor keeps the
  // all-ones quotient regardless of operand signs.
  always_comb begin
    prod_s   = $signed({acc_hi_i, acc_lo_i});
    quot_s   = $signed(acc_lo_i);
    rem_s    = $signed(acc_hi_i);
    res_hi_o = acc_hi_i;
    res_lo_o = acc_lo_i;
    if (is_div_i) begin
      if (prod_neg_i && !div_zero_i) begin
        quot_s = -quot_s;
      end
      if (rem_neg_i) begin
        rem_s = -rem_s;
      end
      res_hi_o = $unsigned(rem_s);
      res_lo_o = $unsigned(quot_s);
    end else begin
      if (prod_neg_i) begin
        prod_s = -prod_s;
      end
      {res_hi_o, res_lo_o} = $unsigned(prod_s);
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage with architectural
// HI/LO registers. Runs WIDTH iterations in CALC, fixes signs in FIX, and
// stalls the pipeline while busy.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] regaData,
  input  logic [WIDTH-1:0] regbData,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             is_div_q, prod_neg_q, rem_neg_q, div_zero_q;

  logic             op_valid;
  logic             accept;
  logic             fix_wr;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, res_hi, res_lo;

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
    if (v < 0) begin
      return $unsigned(-v);
    end
    return $unsigned(v);
  endfunction

  assign op_valid = (start == Valid) && is_mdu_op(op);
  assign accept   = op_valid && (state_q == MduIdle) && !flush;
  assign fix_wr   = (state_q == MduFix) && !flush;
  assign stall    = busy_q | (op_valid & (state_q == MduIdle));
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Operand magnitudes and signs for the op being issued.
  always_comb begin
    a_neg = 1'b0;
    b_neg = 1'b0;
    abs_a = regaData;
    abs_b = regbData;
    if (is_signed_op(op)) begin
      a_neg = regaData[WIDTH-1];
      b_neg = regbData[WIDTH-1];
      abs_a = abs_w($signed(regaData));
      abs_b = abs_w($signed(regbData));
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div_i   (is_div_q),
    .acc_hi_i   (acc_hi_q),
    .acc_lo_i   (acc_lo_q),
    .opnd_i     (opnd_q),
    .prod_neg_i (prod_neg_q),
    .rem_neg_i  (rem_neg_q),
    .div_zero_i (div_zero_q),
    .nxt_hi_o   (nxt_hi),
    .nxt_lo_o   (nxt_lo),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo)
  );

  // Next-state logic: IDLE -> CALC -> FIX -> IDLE, flush aborts to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MduIdle: if (accept) state_d = MduCalc;
      MduCalc: begin
        if (flush) begin
          state_d = MduIdle;
        end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MduFix;
        end
      end
      MduFix:  state_d = MduIdle;
      default: state_d = MduIdle;
    endcase
  end

  // State, busy and done registers.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state_q <= MduIdle;
      busy_q  <= Invalid;
      done_q  <= Invalid;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != MduIdle);
      done_q  <= fix_wr;
    end
  end

  // Operand latch on issue and one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      is_div_q   <= is_div_op(op);
      prod_neg_q <= a_neg ^ b_neg;
      rem_neg_q  <= a_neg;
      div_zero_q <= (regbData == '0);
      if (is_div_op(op)) begin
        acc_lo_q <= abs_a;
        opnd_q   <= abs_b;
      end else begin
        acc_lo_q <= abs_b;
        opnd_q   <= abs_a;
      end
    end else if ((state_q == MduCalc) && !flush) begin
      cnt_q    <= cnt_q + CNT_W'(1);
      acc_hi_q <= nxt_hi;
      acc_lo_q <= nxt_lo;
    end
  end

  // HI/LO: result write from FIX wins; mthi/mtlo only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (state_q == MduIdle) begin
      if (hi_we) hi_q <= wdata;
      if (lo_we) lo_q <= wdata;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  op;
  logic [31:0] regaData, regbData;
  logic        flush, hi_we, lo_we;
  logic [31:0] wdata;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .regaData (regaData),
    .regbData (regbData),
    .flush    (flush),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble the operand inputs afterwards, and check timing and result.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int pulses;
    pulses = 0;
    @(negedge clk);
    start = 1'b1; op = o; regaData = a; regbData = b;
    #1 chk({tag, ".stall_e0"}, stall, 1);
    @(negedge clk);
    start = 1'b0; op = 6'h00; regaData = $urandom; regbData = $urandom;
    chk({tag, ".busy"}, busy, 1);
    repeat (32) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk({tag, ".early_done"}, pulses, 0);
    chk({tag, ".busy_fix"}, busy, 1);
    @(negedge clk);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".hi"}, hi, eh);
    chk({tag, ".lo"}, lo, el);
    @(negedge clk);
    chk({tag, ".done_off"}, done, 0);
    chk({tag, ".busy_off"}, busy, 0);
    chk({tag, ".stall_off"}, stall, 0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; start = 1'b0; op = 6'h00; regaData = '0; regbData = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.hi", hi, 0);
    chk("rst.lo", lo, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.stall", stall, 0);
    rst = 1'b1;

    run_op("multu_7x6",   Multu, 32'd7,        32'd6,        32'h0,        32'h0000002A);
    run_op("mult_m3x5",   Mult,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max",   Multu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_m7_2",    Div,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_100_7",  Divu,  32'd100,      32'd7,        32'd2,        32'd14);
    run_op("divu_by0",    Divu,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF);
    run_op("div_neg_by0", Div,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_ovf",     Div,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);

    // Non-MDU op does not start the unit.
    @(negedge clk);
    start = 1'b1; op = 6'b100000; regaData = 32'd3; regbData = 32'd3;
    #1 chk("badop.stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    chk("badop.busy", busy, 0);

    // Flush in IDLE suppresses a simultaneous start.
    start = 1'b1; op = Mult; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idleflush.busy", busy, 0);

    // mthi, then an aborted Mult; a busy-time mthi is ignored.
    hi_we = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi.hi", hi, 32'hA5A5A5A5);
    start = 1'b1; op = Mult; regaData = 32'd2; regbData = 32'd3;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      hi_we = (i == 4);
      wdata = 32'h0;
      if (done) pulses++;
    end
    hi_we = 1'b0;
    chk("flush.busy_before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.busy_after", busy, 0);
    chk("flush.hi", hi, 32'hA5A5A5A5);
    chk("flush.lo", lo, 32'h80000000);
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush.no_done", pulses, 0);
    chk("flush.hi_late", hi, 32'hA5A5A5A5);

    // Asynchronous reset mid-CALC.
    start = 1'b1; op = Multu; regaData = 32'd9; regbData = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst.hi", hi, 0);
    chk("arst.lo", lo, 0);
    chk("arst.busy", busy, 0);
    chk("arst.stall", stall, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_rst_2x2", Multu, 32'd2, 32'd2, 32'h0, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and its sequencer for the EX stage, with architectural HI/LO registers.
- Accepts Mult, Multu, Div and Divu ops from decode, together with the two operand words.
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, then writes HI/LO.
- Holds the pipeline with a stall request while busy.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- CNT_W, 6: iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  decoded op is valid this cycle.
- op  in  6  decode op code; only Mult/Multu/Div/Divu start the unit.
- regaData  in  WIDTH  multiplicand / dividend.
- regbData  in  WIDTH  multiplier / divisor.
- flush  in  1  abort the in-flight op (branch/exception flush).
- hi_we  in  1  mthi write.
- lo_we  in  1  mtlo write.
- wdata  in  WIDTH  data for mthi/mtlo.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  registered; high in CALC or FIX.
- done  out  1  one-cycle pulse after the HI/LO update.
- stall  out  1  combinational: busy | (start & op in {Mult,Multu,Div,Divu} & state==IDLE).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, all internal accumulators 0. Any operation in flight is discarded.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - A valid start op latches the operands and goes to CALC with cnt=0.
  - For Mult/Div, the operands latch as absolute values. The product sign latches as signA^signB. The remainder sign latches as signA.
  - For Multu/Divu, the operands latch raw and both signs are 0.
  - Any other op leaves the unit in IDLE with stall=0.
- CALC: one iteration per cycle; cnt increments; at cnt==WIDTH-1 the next state is FIX.
  - Multiply: 2*WIDTH accumulator. If the current multiplier LSB is 1, add the multiplicand into the upper half. Then shift right 1, keeping the carry.
  - Divide: shift {rem,quot} left 1. If rem >= divisor, subtract it and set quot LSB=1.
- FIX: apply sign correction, write the result, pulse done=1, return to IDLE.
  - Multiply: negate the 2*WIDTH product if the product sign is set. {hi,lo} = product.
  - Divide: negate quot if the product sign is set; negate rem if the remainder sign is set. lo=quot, hi=rem.
- Latency: start is sampled at edge E0. HI/LO and done are visible after edge E0+WIDTH+1, i.e. 33 edges for WIDTH=32. Back-to-back starts are accepted in the cycle done is high.
- Divide by zero: the iterations still run. Result is lo = all ones, hi = dividend (raw input, unsigned or signed). No exception is raised.
- Signed overflow (Div of most-negative by -1): lo = most-negative, hi = 0, produced naturally by the abs/negate path.
- flush:
  - In CALC or FIX: go to IDLE next edge; HI/LO unchanged; done stays 0.
  - In IDLE: a simultaneous start is ignored.
- hi_we/lo_we: honoured only in IDLE and take effect at the next edge. If asserted in the same cycle as a start, the write happens and the start is also accepted. While busy they are ignored, because the pipeline is stalled upstream.
- The FIX write has priority over hi_we/lo_we. Since those writes are ignored while busy, the two never collide.
- The operand inputs may change after E0; the unit uses only the latched copies.

Decomposition:
- Op codes Mult/Multu/Div/Divu and the Valid/Invalid/RstEnable constants stay in the shared define file.
- Add the state encodings MduIdle/MduCalc/MduFix to the shared define file.
- One sub-module is natural: mdu_iter, holding the per-cycle shift-add / shift-subtract datapath and the sign fixup. It is selected by a mul/div flag.
- mdu_ctrl keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- Multu: start with 7 and 6. stall is high from E0. At E0+33: lo=0x0000002A, hi=0, done pulses once. The following cycle: busy=0, stall=0.
- Mult: -3 (0xFFFFFFFD) times 5. Result lo=0xFFFFFFF1, hi=0xFFFFFFFF. Multu 0xFFFFFFFF times 0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.
- Div -7/2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF. Divu 100/7 gives lo=14, hi=2.
- Divu 0x1234/0 gives lo=0xFFFFFFFF, hi=0x00001234.
- Div 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
- Mthi 0xA5A5A5A5 in IDLE, then Mult 2*3 issued with flush at cycle 10: hi stays 0xA5A5A5A5, done never asserts, busy=0 after the flush edge.
- Assert rst=0 mid-CALC, asynchronously between edges: hi=lo=0, busy=0, stall=0 immediately. After release, a new Multu 2*2 gives lo=4.
